encoder_8x3_scan: RTL and testbench

//   Sequential 8-to-3 encoder, the inverse of the team's 3x8 one-hot decoder.

---
 rtl/encoder_8x3_scan.sv | 115 +++++++++++
 tb/tb_encoder_8x3_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3_scan.sv
// ============================================================================
// encoder_8x3_scan : serialises a multi-hot 8-bit vector into 3-bit indices
// Rev 1.0
// ============================================================================
`default_nettype none

module encoder_8x3_scan #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pending;
  logic       r_out_valid;
  logic [2:0] r_out_code;
  logic       r_out_last;
  logic       r_out_zero;

  logic [7:0] w_src;
  logic [2:0] w_idx;
  logic [7:0] w_onehot;
  logic [7:0] w_rest;

  // Later loop iterations override earlier ones, so the loop order decides
  // whether the lowest or highest set bit wins.
  function automatic logic [2:0] first_bit(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (vec[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // The same selector serves the first beat (from in_data) and later beats.
  assign w_src    = (r_state == IDLE) ? in_data : r_pending;
  assign w_idx    = first_bit(w_src);
  assign w_onehot = 8'b1 << w_idx;
  assign w_rest   = w_src & ~w_onehot;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_last  = r_out_last;
  assign out_zero  = r_out_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_code  <= 3'd0;
      r_out_last  <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
            if (in_data != 8'h00) begin
              r_out_code <= w_idx;
              r_pending  <= w_rest;
              r_out_last <= (w_rest == 8'h00);
              r_out_zero <= 1'b0;
            end else begin
              // Empty vector still produces one marker beat.
              r_out_code <= 3'd0;
              r_pending  <= 8'h00;
              r_out_last <= 1'b1;
              r_out_zero <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_zero  <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_out_code <= w_idx;
              r_pending  <= w_rest;
              r_out_last <= (w_rest == 8'h00);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_encoder_8x3_scan.sv
// ============================================================================
// tb_encoder_8x3_scan : directed self-checking bench for encoder_8x3_scan
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_encoder_8x3_scan;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_zero;

  logic       m_in_valid;
  logic       m_in_ready;
  logic [7:0] m_in_data;
  logic       m_out_valid;
  logic       m_out_ready;
  logic [2:0] m_out_code;
  logic       m_out_last;
  logic       m_out_zero;

  int n_tests;
  int n_fail;

  encoder_8x3_scan #(.MSB_FIRST(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  encoder_8x3_scan #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_data   (m_in_data),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_code  (m_out_code),
    .out_last  (m_out_last),
    .out_zero  (m_out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the LSB-first DUT idle; ends idle again.
  task automatic run_vec(input logic [7:0] data, input int n,
                         input logic [23:0] codes, input logic zero);
    in_data   = data;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("beat_valid", {7'd0, out_valid}, 8'd1);
      check("beat_code", {5'd0, out_code}, {5'd0, codes[3*i +: 3]});
      check("beat_last", {7'd0, out_last}, {7'd0, (i == n - 1)});
      check("beat_zero", {7'd0, out_zero}, {7'd0, zero});
      check("busy_in_ready", {7'd0, in_ready}, 8'd0);
    end
    @(negedge clk);
    check("end_valid", {7'd0, out_valid}, 8'd0);
    check("end_in_ready", {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    logic [7:0]  recon;
    logic [11:0] msb_codes;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;
    m_in_valid  = 1'b0;
    m_in_data   = 8'h00;
    m_out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_code", {5'd0, out_code}, 8'd0);
    check("rst_last", {7'd0, out_last}, 8'd0);
    check("rst_zero", {7'd0, out_zero}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {7'd0, in_ready}, 8'd1);

    // Single bit, vector with gaps, empty vector
    run_vec(8'h01, 1, 24'd0, 1'b0);
    run_vec(8'hA5, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, 1'b0);
    run_vec(8'h00, 1, 24'd0, 1'b1);

    // All bits set with two stall cycles per beat and ignored in_valid pulses
    in_data   = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ff_code", {5'd0, out_code}, 8'(i));
      check("ff_last", {7'd0, out_last}, {7'd0, (i == 7)});
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      @(negedge clk);
      in_valid = 1'b0;
      check("ff_stall_valid", {7'd0, out_valid}, 8'd1);
      check("ff_stall_code", {5'd0, out_code}, 8'(i));
      check("ff_stall_in_ready", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
      check("ff_stall2_code", {5'd0, out_code}, 8'(i));
      check("ff_stall2_last", {7'd0, out_last}, {7'd0, (i == 7)});
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("ff_end_valid", {7'd0, out_valid}, 8'd0);
    check("ff_end_in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    check("ff_no_extra_valid", {7'd0, out_valid}, 8'd0);

    // Reset in the middle of a vector
    in_data   = 8'hF0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("f0_code0", {5'd0, out_code}, 8'd4);
    @(negedge clk);
    check("f0_code1", {5'd0, out_code}, 8'd5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {7'd0, out_valid}, 8'd0);
    check("midrst_in_ready", {7'd0, in_ready}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_valid", {7'd0, out_valid}, 8'd0);
    check("after_rst_in_ready", {7'd0, in_ready}, 8'd1);
    run_vec(8'h08, 1, {21'd0, 3'd3}, 1'b0);

    // MSB-first instance, codes decoded and ORed back together
    msb_codes   = {3'd0, 3'd2, 3'd5, 3'd7};
    recon       = 8'h00;
    m_in_data   = 8'hA5;
    m_in_valid  = 1'b1;
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      check("msb_valid", {7'd0, m_out_valid}, 8'd1);
      check("msb_code", {5'd0, m_out_code}, {5'd0, msb_codes[3*i +: 3]});
      check("msb_last", {7'd0, m_out_last}, {7'd0, (i == 3)});
      recon = recon | (8'b1 << m_out_code);
    end
    @(negedge clk);
    check("msb_end_valid", {7'd0, m_out_valid}, 8'd0);
    check("msb_roundtrip", recon, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
